cacheline_arbiter: RTL
======================

Name: cacheline_arbiter

Overview:
- N-port cacheline memory arbiter placed between the per-cache miss ports (I-cache, D-cache, later L2/prefetch ports) and the single cacheline memory interface below them.
- Accepts whole-line read/write requests from NUM_PORTS clients, serialises them onto one memory channel, and returns the response to the granted client only.
- Generalised successor of the fixed two-cache top level: port count, widths and arbitration mode are parameters.

Parameters:
- NUM_PORTS, 2, number of requesting clients (>=2); port 0 = I-cache, port 1 = D-cache by convention.
- ADDR_WIDTH, 32, byte address width; line-aligned, low bits passed through unchanged.
- LINE_WIDTH, 256, cacheline data width in bits.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_read  in  NUM_PORTS  per-client line read request, level, held until req_resp
- req_write  in  NUM_PORTS  per-client line write request, level, held until req_resp
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-client address, slice i = client i
- req_wdata  in  NUM_PORTS*LINE_WIDTH  per-client write line
- req_resp  out  NUM_PORTS  one-hot single-cycle completion pulse
- req_rdata  out  LINE_WIDTH  read line, shared by all clients, valid when own req_resp=1
- mem_read  out  1  memory line read
- mem_write  out  1  memory line write
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write line
- mem_resp  in  1  memory completion, single cycle
- mem_rdata  in  LINE_WIDTH  memory read line, valid with mem_resp

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. Single clock domain.
- Reset values: state IDLE, req_resp=0, req_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, rr pointer=NUM_PORTS-1 (so port 0 is searched first).
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - pending[i] = req_read[i] | req_write[i].
  - If any pending bit is set, pick a winner g.
  - Latch g, op (write if req_write[g], else read), req_address[g] and req_wdata[g] into registers, then go to BUSY.
  - No memory strobe is driven in this cycle.
- BUSY:
  - mem_read/mem_write are driven from the latched op, with mem_address/mem_wdata from the latched registers. All are registered outputs and held stable for the whole transaction.
  - Client inputs are ignored.
  - On mem_resp=1: register mem_rdata into req_rdata, drop mem_read/mem_write in the next cycle, go to RESP.
- RESP:
  - req_resp[g]=1 for exactly one cycle; all other bits 0.
  - Unconditionally return to IDLE.
  - req_rdata holds its value until the next read completes. Writes leave req_rdata unchanged.
- Latency: request seen in IDLE cycle T; mem strobe asserted at T+1; mem_resp at cycle M; req_resp at M+1; next grant evaluated no earlier than M+2.
- Clients must deassert their request in the cycle after seeing req_resp. IDLE re-arbitrates on current levels, so a stale request would be re-served.
- Arbitration:
  - Fixed mode: g = lowest set pending index.
  - Round-robin mode: search starts at (ptr+1) mod NUM_PORTS and wraps; ptr <= g on each grant.
- Boundary conditions:
  - Simultaneous requests: exactly one grant per transaction. No starvation in RR mode (bounded by NUM_PORTS transactions).
  - req_read and req_write both set on one port: treated as write. The bench flags it as illegal.
  - mem_resp while in IDLE or RESP: ignored, no req_resp.
  - Request arriving during BUSY/RESP: waits; never preempts.
  - rst during BUSY or RESP: state IDLE next cycle, strobes 0, any pending req_resp suppressed. The in-flight transaction is abandoned; memory is assumed reset together.

Decomposition:
- Package cacheline_arb_pkg holds:
  - arb_state_t enum (IDLE, BUSY, RESP);
  - arb_op_t enum (OP_READ, OP_WRITE);
  - mode constants ARB_FIXED=0, ARB_RR=1.
- Sub-module arb_picker: combinational, parameterised by NUM_PORTS and RR_MODE. Inputs pending and ptr; outputs grant index and a valid bit.
- Top holds the FSM, latch registers and the ptr register.

Test Plan:
- Single read: port 0 req_read, addr 0x00000040; memory answers after 5 cycles with line 0xA5…A5 -> mem_read high with mem_address 0x40 for 5 cycles; req_resp=2'b01 one cycle later; req_rdata=0xA5…A5; req_resp[1] never asserted.
- Single write: port 1 writes 0x1234…, addr 0x80 -> mem_write with mem_wdata 0x1234…; req_resp=2'b10; req_rdata unchanged from the previous value.
- Contention, RR_MODE=1, NUM_PORTS=2: both ports request from reset, each re-requesting immediately -> grant order 0,1,0,1 across 4 transactions.
- Contention, RR_MODE=0, NUM_PORTS=4: ports 1 and 3 pending, port 3 re-requests continuously -> port 1 served first; port 3 served only when port 1 is idle.
- Reset mid-BUSY: assert rst for 1 cycle while mem_read=1 -> next cycle mem_read=0, state IDLE, no req_resp; a fresh request afterwards completes normally.
- Spurious mem_resp in IDLE, plus a port asserting read and write together -> no req_resp from the spurious mem_resp; the dual request is issued as mem_write and the assertion fires.

Source files
------------

// File: rtl/cacheline_arb_pkg.sv
// Shared types and constants for the cacheline memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_op_t    : latched memory operation of the granted client
//   ARB_FIXED / ARB_RR : arbitration mode selectors for RR_MODE
//   ptr_width() : width of a client index for a given port count
package cacheline_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cacheline_arbiter_picker.sv
// Combinational winner selection for the cacheline arbiter.
// Ports:
//   i_pending : per-client request level (read | write)
//   i_ptr     : index of the last granted client (round-robin pointer)
//   o_grant   : index of the selected client
//   o_valid   : at least one client is pending
module arb_picker
    import cacheline_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int RR_MODE   = ARB_RR,
    localparam int PTR_W    = ptr_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_pending,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [PTR_W-1:0]     o_grant,
    output logic                 o_valid
);

    logic [PTR_W-1:0] w_start;
    logic [PTR_W-1:0] w_idx;

    // Fixed priority is the round-robin search with the pointer pinned to the
    // last port, so the scan always begins at port 0.
    assign w_start = (RR_MODE == ARB_RR) ? i_ptr : PTR_W'(NUM_PORTS - 1);

    // Scan in reverse search order; the last hit is the first client in
    // (start+1, start+2, ...) order.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = PTR_W'((int'(w_start) + k) % NUM_PORTS);
            if (i_pending[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// N-port cacheline memory arbiter. Serialises whole-line read/write requests
// from NUM_PORTS cache miss ports onto a single memory channel and returns the
// completion to the granted client only.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_read/req_write  : per-client request levels, held until req_resp
//   req_address         : per-client address, slice i = client i
//   req_wdata           : per-client write line, slice i = client i
//   req_resp            : one-hot single-cycle completion pulse
//   req_rdata           : last read line, shared by all clients
//   mem_read/mem_write  : memory strobes, held for the whole transaction
//   mem_address/wdata   : memory request, held for the whole transaction
//   mem_resp/mem_rdata  : memory completion and read line
//
// state | meaning
// IDLE  | arbitrate on current request levels, latch the winner
// BUSY  | memory strobe asserted, waiting for mem_resp
// RESP  | pulse req_resp to the winner for one cycle
module cacheline_arbiter
    import cacheline_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int RR_MODE    = ARB_RR
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_resp,
    input  logic [LINE_WIDTH-1:0]            mem_rdata
);

    localparam int PTR_W = ptr_width(NUM_PORTS);

    arb_state_t              r_state;
    arb_state_t              w_state_next;
    arb_op_t                 r_op;
    logic [PTR_W-1:0]        r_grant;
    logic [PTR_W-1:0]        r_ptr;
    logic [NUM_PORTS-1:0]    r_req_resp;
    logic [LINE_WIDTH-1:0]   r_rdata;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wdata;
    logic                    r_mem_read;
    logic                    r_mem_write;

    logic [NUM_PORTS-1:0]    w_pending;
    logic [PTR_W-1:0]        w_grant;
    logic                    w_valid;
    logic [ADDR_WIDTH-1:0]   w_addr_sel;
    logic [LINE_WIDTH-1:0]   w_wdata_sel;
    logic                    w_sel_write;

    assign w_pending = req_read | req_write;

    arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .RR_MODE   (RR_MODE)
    ) u_picker (
        .i_pending (w_pending),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_valid   (w_valid)
    );

    // Client mux; a port raising both read and write is served as a write.
    always_comb begin
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant == PTR_W'(i)) begin
                w_addr_sel  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata_sel = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
                w_sel_write = req_write[i];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_valid)  w_state_next = BUSY;
            BUSY:    if (mem_resp) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= OP_READ;
            r_grant     <= '0;
            r_ptr       <= PTR_W'(NUM_PORTS - 1);
            r_req_resp  <= '0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_req_resp <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant     <= w_grant;
                        r_op        <= w_sel_write ? OP_WRITE : OP_READ;
                        r_addr      <= w_addr_sel;
                        r_wdata     <= w_wdata_sel;
                        r_mem_read  <= ~w_sel_write;
                        r_mem_write <= w_sel_write;
                        if (RR_MODE == ARB_RR) begin
                            r_ptr <= w_grant;
                        end
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_op == OP_READ) begin
                            r_rdata <= mem_rdata;
                        end
                        r_req_resp <= NUM_PORTS'(1) << r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_resp    = r_req_resp;
    assign req_rdata   = r_rdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;

endmodule
